// File: rtl/gray_count_tx_pkg.sv
// gray_count_tx_pkg: shared types and helpers for the Gray count producer.
//   state_t  - publish FSM states (IDLE: hold timer is 0, HOLD: timer running)
//   timer_w  - hold timer width: clog2(HOLD_CYCLES), at least 1 bit
//   bin2gray - binary to reflected Gray conversion, MAX_BITS wide; callers
//              zero-extend the input and truncate the result to their width
package gray_count_tx_pkg;

  localparam int MAX_BITS = 64;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // The timer only ever holds HOLD_CYCLES-1, so clog2(HOLD_CYCLES) bits suffice.
  function automatic int timer_w(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

  function automatic logic [MAX_BITS-1:0] bin2gray(input logic [MAX_BITS-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_count_tx_if.sv
// gray_count_tx_if: increment handshake and published count bundle.
//   inc_valid/inc_ready  - increment request handshake
//   count_bin/count_gray - published count, binary and Gray
//   pending, busy        - accepted-but-unpublished increments, activity flag
//   gray_err             - sticky Gray-step checker flag
// Modports: slave = the producer block, master = the requester/observer.
interface gray_count_tx_if #(
  parameter int BITS      = 32,
  parameter int PEND_BITS = 8
) ();
  logic                 inc_valid;
  logic                 inc_ready;
  logic [BITS-1:0]      count_bin;
  logic [BITS-1:0]      count_gray;
  logic [PEND_BITS-1:0] pending;
  logic                 busy;
  logic                 gray_err;

  modport slave (
    input  inc_valid,
    output inc_ready, count_bin, count_gray, pending, busy, gray_err
  );

  modport master (
    output inc_valid,
    input  inc_ready, count_bin, count_gray, pending, busy, gray_err
  );
endinterface

// File: rtl/gray_count_tx_gray_step_check.sv
// gray_step_check: sticky checker for the published Gray count.
//   clk, rst_n - block clock, synchronous active-low reset
//   count_bin  - registered binary count
//   count_gray - Gray count as seen on the output bus
//   gray_err   - sets one cycle after a multi-bit Gray step or a Gray value
//                that does not encode count_bin; held until reset
// Only instantiated when GRAY_COUNT_TX_CHECK_EN is defined.
module gray_step_check
  import gray_count_tx_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] count_bin,
  input  logic [BITS-1:0] count_gray,
  output logic            gray_err
);

  logic [BITS-1:0] prev_q, diff;
  logic            multi, enc_bad, err_q;

  // x & (x-1) clears the lowest set bit; nonzero means more than one bit moved.
  assign diff    = prev_q ^ count_gray;
  assign multi   = (diff & (diff - 1'b1)) != '0;
  assign enc_bad = count_gray != BITS'(bin2gray(MAX_BITS'(count_bin)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= count_gray;
      err_q  <= err_q | multi | enc_bad;
    end
  end

  assign gray_err = err_q;

endmodule

// File: rtl/gray_count_tx.sv
// gray_count_tx: Gray-coded count producer for a slower sampling domain.
//   clk, rst_n - block clock, synchronous active-low reset
//   bus        - gray_count_tx_if.slave: inc_valid/inc_ready handshake,
//                count_bin, count_gray, pending, busy, gray_err
// Increments are buffered in a pending counter and published one at a time,
// at most once every HOLD_CYCLES edges, so the destination never sees more
// than one Gray bit change between its samples.
// Optional: define GRAY_COUNT_TX_CHECK_EN to add the Gray-step checker;
// otherwise gray_err is tied low.
module gray_count_tx
  import gray_count_tx_pkg::*;
#(
  parameter int BITS        = 32,
  parameter int HOLD_CYCLES = 2,
  parameter int PEND_BITS   = 8
) (
  input logic              clk,
  input logic              rst_n,
  gray_count_tx_if.slave   bus
);

  localparam int                   TW        = timer_w(HOLD_CYCLES);
  localparam logic [TW-1:0]        HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [PEND_BITS-1:0] PEND_CAP  = '1;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q;
  logic [BITS-1:0]      bin_q, gray_q, bin_nxt;
  logic [PEND_BITS-1:0] pend_q;
  logic                 ready, publish, busy, accept, err;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: with HOLD_CYCLES==1 the timer loads 0 and HOLD is never used.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pend_q != '0 && HOLD_CYCLES > 1) state_d = HOLD;
      HOLD:    if (timer_q == TW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: all from registers, no path from inc_valid to inc_ready.
  always_comb begin
    ready   = (pend_q != PEND_CAP);
    publish = (state_q == IDLE) && (pend_q != '0);
    busy    = (pend_q != '0) || (timer_q != '0);
  end

  assign accept  = bus.inc_valid && ready;
  assign bin_nxt = bin_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q   <= '0;
      gray_q  <= '0;
      timer_q <= '0;
      pend_q  <= '0;
    end else begin
      if (publish) begin
        bin_q   <= bin_nxt;
        gray_q  <= BITS'(bin2gray(MAX_BITS'(bin_nxt)));
        timer_q <= HOLD_LOAD;
      end else if (timer_q != '0) begin
        timer_q <= timer_q - 1'b1;
      end
      // Accept and publish on the same edge cancel out.
      case ({accept, publish})
        2'b10:   pend_q <= pend_q + 1'b1;
        2'b01:   pend_q <= pend_q - 1'b1;
        default: pend_q <= pend_q;
      endcase
    end
  end

  assign bus.inc_ready  = ready;
  assign bus.count_bin  = bin_q;
  assign bus.count_gray = gray_q;
  assign bus.pending    = pend_q;
  assign bus.busy       = busy;
  assign bus.gray_err   = err;

  // The checker watches the bus copy of count_gray so it sees exactly what
  // the synchroniser sees.
`ifdef GRAY_COUNT_TX_CHECK_EN
  gray_step_check #(.BITS(BITS)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_bin  (bin_q),
    .count_gray (bus.count_gray),
    .gray_err   (err)
  );
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_count_tx.sv
// tb_gray_count_tx: self-checking bench for gray_count_tx.
// Config: BITS=4, HOLD_CYCLES=3, PEND_BITS=3 (capacity 7).
// A scoreboard pushes the expected count for every accepted request and pops
// it whenever the DUT publishes; a cycle table covers latency and hold
// spacing; hand-written sequences cover saturation, wrap, reset and checker.
`timescale 1ns/1ps
module tb_gray_count_tx;

  localparam int BITS = 4;
  localparam int HOLD = 3;
  localparam int PB   = 3;

  logic clk, rst_n;
  int   n_chk, n_fail, n_acc;

  logic [BITS-1:0] sbq[$];
  logic [BITS-1:0] exp_cnt, last_bin, last_gray, e;
  logic            acc_now, rst_now;

  gray_count_tx_if #(.BITS(BITS), .PEND_BITS(PB)) bus ();

  gray_count_tx #(.BITS(BITS), .HOLD_CYCLES(HOLD), .PEND_BITS(PB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: sample the handshake at the edge, compare 1ns later.
  always @(posedge clk) begin
    acc_now = rst_n && bus.inc_valid && bus.inc_ready;
    rst_now = rst_n;
    #1;
    if (!rst_now) begin
      sbq.delete();
      exp_cnt   = '0;
      last_bin  = '0;
      last_gray = '0;
    end else begin
      if (acc_now) begin
        exp_cnt = exp_cnt + 1'b1;
        sbq.push_back(exp_cnt);
        n_acc++;
      end
      if (bus.count_bin != last_bin) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 32'(sbq.size()), 1);
        end else begin
          e = sbq.pop_front();
          chk("sb_bin", 32'(bus.count_bin), 32'(e));
          chk("sb_gray", 32'(bus.count_gray), 32'(e ^ (e >> 1)));
        end
        chk("gray_step", 32'($countones(bus.count_gray ^ last_gray)), 1);
        last_bin  = bus.count_bin;
        last_gray = bus.count_gray;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && bus.busy; i++) step();
    chk("idle_timeout", 32'(bus.busy), 0);
  endtask

  typedef struct {
    logic            v;
    logic [BITS-1:0] bin;
    logic [BITS-1:0] gray;
    logic [PB-1:0]   pend;
    logic            busy;
    logic            ready;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int base, peak, saw_full, saw_restore;
    logic            prev_ready;
    logic [BITS-1:0] prev_bin;

    n_chk = 0; n_fail = 0; n_acc = 0;
    exp_cnt = '0; last_bin = '0; last_gray = '0;

    // Single pulse then a back-to-back pair, one row per clock edge.
    tbl[0]  = '{1'b1, 4'd0, 4'd0, 3'd1, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 4'd1, 4'd1, 3'd0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 4'd1, 4'd1, 3'd0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 4'd1, 4'd1, 3'd0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 4'd1, 4'd1, 3'd1, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 4'd2, 4'd3, 3'd1, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 4'd2, 4'd3, 3'd1, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 4'd2, 4'd3, 3'd1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 4'd3, 4'd2, 3'd0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 4'd3, 4'd2, 3'd0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 4'd3, 4'd2, 3'd0, 1'b0, 1'b1};

    // Reset, with a request held to show it is ignored.
    rst_n = 1'b0;
    bus.inc_valid = 1'b1;
    step();
    step();
    bus.inc_valid = 1'b0;
    chk("rst_bin", 32'(bus.count_bin), 0);
    chk("rst_gray", 32'(bus.count_gray), 0);
    chk("rst_pend", 32'(bus.pending), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ready", 32'(bus.inc_ready), 1);
    chk("rst_err", 32'(bus.gray_err), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      bus.inc_valid = tbl[i].v;
      step();
      chk($sformatf("tbl%0d_bin", i), 32'(bus.count_bin), 32'(tbl[i].bin));
      chk($sformatf("tbl%0d_gray", i), 32'(bus.count_gray), 32'(tbl[i].gray));
      chk($sformatf("tbl%0d_pend", i), 32'(bus.pending), 32'(tbl[i].pend));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_ready", i), 32'(bus.inc_ready), 32'(tbl[i].ready));
    end
    bus.inc_valid = 1'b0;

    // Ten cycles of requests: pending climbs to capacity on the last one.
    do_reset();
    base = n_acc;
    peak = 0;
    bus.inc_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (int'(bus.pending) > peak) peak = int'(bus.pending);
    end
    bus.inc_valid = 1'b0;
    chk("ten_accepts", 32'(n_acc - base), 10);
    chk("ten_peak", 32'(peak), 7);
    chk("ten_full_ready", 32'(bus.inc_ready), 0);
    wait_idle(100);
    chk("ten_bin", 32'(bus.count_bin), 10);
    chk("ten_gray", 32'(bus.count_gray), 32'h0F);

    // Continuous requests against a full buffer.
    saw_full = 0;
    saw_restore = 0;
    for (int i = 0; i < 40; i++) begin
      bus.inc_valid = 1'b1;
      prev_ready = bus.inc_ready;
      prev_bin   = bus.count_bin;
      step();
      if (!bus.inc_ready) saw_full = 1;
      if (!prev_ready && bus.count_bin != prev_bin) begin
        saw_restore++;
        chk("ready_restore", 32'(bus.inc_ready), 1);
      end
    end
    bus.inc_valid = 1'b0;
    chk("sat_saw_full", 32'(saw_full), 1);
    chk("sat_saw_restore", 32'(saw_restore > 0), 1);
    wait_idle(100);
    chk("sat_sb_empty", 32'(sbq.size()), 0);
    chk("sat_bin", 32'(bus.count_bin), 32'(exp_cnt));

    // Wrap: 15 increments then one more.
    do_reset();
    base = n_acc;
    bus.inc_valid = 1'b1;
    for (int i = 0; i < 200 && (n_acc - base) < 15; i++) step();
    bus.inc_valid = 1'b0;
    wait_idle(100);
    chk("wrap_pre_bin", 32'(bus.count_bin), 32'hF);
    chk("wrap_pre_gray", 32'(bus.count_gray), 32'h8);
    bus.inc_valid = 1'b1;
    step();
    bus.inc_valid = 1'b0;
    wait_idle(100);
    chk("wrap_bin", 32'(bus.count_bin), 0);
    chk("wrap_gray", 32'(bus.count_gray), 0);
    chk("wrap_err", 32'(bus.gray_err), 0);

    // Reset while pending=5 and holding; request held through reset.
    do_reset();
    bus.inc_valid = 1'b1;
    repeat (8) step();
    chk("mid_pend", 32'(bus.pending), 5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.inc_valid = 1'b0;
    chk("mid_rst_bin", 32'(bus.count_bin), 0);
    chk("mid_rst_gray", 32'(bus.count_gray), 0);
    chk("mid_rst_pend", 32'(bus.pending), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_ready", 32'(bus.inc_ready), 1);
    bus.inc_valid = 1'b1;
    step();
    bus.inc_valid = 1'b0;
    wait_idle(100);
    chk("mid_post_bin", 32'(bus.count_bin), 1);
    chk("mid_post_gray", 32'(bus.count_gray), 1);

`ifdef GRAY_COUNT_TX_CHECK_EN
    // Two-bit jump 0x1 -> 0x7 on the bus.
    force bus.count_gray = 4'h7;
    step();
    release bus.count_gray;
    chk("chk_err_set", 32'(bus.gray_err), 1);
    repeat (3) step();
    chk("chk_err_sticky", 32'(bus.gray_err), 1);
    do_reset();
    chk("chk_err_clear", 32'(bus.gray_err), 0);
`else
    chk("err_tied_low", 32'(bus.gray_err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_count_tx.md
Name: gray_count_tx

Overview:
- Single-clock source-side producer of a Gray-coded count for a downstream two-flop synchroniser and Gray-to-binary decoder in a slower clock domain.
- Accepts increment requests over a valid/ready handshake and buffers them in a pending counter.
- Publishes the count at most once every HOLD_CYCLES cycles, so a slower sampling clock only ever sees single-bit Gray transitions.
- Replaces free-running binary counters that the destination cannot safely sample when the source clock is faster.

Parameters:
- BITS, 32, width of the published count (>=2).
- HOLD_CYCLES, 2, minimum clk cycles between successive count updates (>=1); set to ceil(f_clk/f_dst)+1 for fast-to-slow use.
- PEND_BITS, 8, width of the pending-increment counter; capacity is 2^PEND_BITS-1.

Ports:
- clk, in, 1, block clock.
- rst_n, in, 1, synchronous active-low reset.
- inc_valid, in, 1, request to increment the count by one.
- inc_ready, out, 1, request is accepted this cycle when high together with inc_valid.
- count_bin, out, BITS, registered binary count; always equal to the Gray value decoded.
- count_gray, out, BITS, registered Gray count, feeds the CDC synchroniser directly.
- pending, out, PEND_BITS, number of accepted but not yet published increments.
- busy, out, 1, pending!=0 or hold timer!=0.
- gray_err, out, 1, sticky Gray-step violation flag (see Optional Feature).

Behaviour:
- Reset (rst_n low at an edge):
  - count_bin, count_gray, pending, hold timer and gray_err clear to 0.
  - state goes to IDLE.
  - inc_ready=1 and busy=0 combinationally from the cleared registers.
  - Requests are ignored while rst_n is low.
- Accept: inc_valid&&inc_ready at edge N raises pending by 1 at N+1.
- inc_ready = (pending != 2^PEND_BITS-1). It depends only on registers; there is no combinational path from inc_valid.
- States:
  - IDLE (timer==0): if pending!=0, the next edge publishes.
  - HOLD (timer!=0): timer decrements by 1 each edge; at 0 the block returns to IDLE.
- Publish edge:
  - count_bin <= count_bin+1 (mod 2^BITS).
  - count_gray <= nxt^(nxt>>1), where nxt=count_bin+1.
  - pending <= pending-1.
  - timer <= HOLD_CYCLES-1, entering HOLD only if HOLD_CYCLES>1.
  - Successive publishes are exactly HOLD_CYCLES edges apart while pending stays nonzero.
- Latency: a request accepted at edge N with the block idle changes the count at edge N+1, visible in cycle N+2.
- Simultaneous accept and publish: pending is unchanged. A full buffer drains one slot and inc_ready re-asserts the following cycle.
- Wrap-around: count_bin all-ones -> 0; count_gray 100..0 -> 0 (single-bit change).
- count_gray changes by exactly one bit per publish and is otherwise stable. count_gray always equals count_bin^(count_bin>>1).
- Reset mid-operation: pending increments are discarded. The destination domain must be reset in the same reset sequence.

Optional Feature:
- Macro: GRAY_COUNT_TX_CHECK_EN.
- With the macro:
  - A registered copy of the previous count_gray is kept.
  - gray_err sets (sticky until reset) one cycle after any edge where popcount(prev^count_gray)>1.
  - gray_err also sets when count_gray != count_bin^(count_bin>>1).
- Without the macro: gray_err is tied to 0, the checker flops are absent, and the port list is unchanged.

Decomposition:
- Shared package:
  - bin2gray function.
  - Timer-width localparam (clog2 of HOLD_CYCLES, min 1).
  - Pending-capacity localparam.
- One sub-module, gray_step_check: the one-bit-change and encoding checker, instantiated only under GRAY_COUNT_TX_CHECK_EN.

Test Plan:
- Reset, then single inc_valid pulse, HOLD_CYCLES=2 -> count_bin=1 and count_gray=1 two cycles after the request; busy low again after the hold expires.
- inc_valid held high for 10 cycles, HOLD_CYCLES=3 -> updates 3 cycles apart; pending peaks then drains; final count_bin=10, count_gray=0xF.
- PEND_BITS=2, inc_valid held high continuously -> pending reaches 3 and inc_ready drops. The next publish restores inc_ready one cycle later, with no lost or duplicated increments versus the accept count.
- BITS=4, preload via 15 increments then one more -> count_bin 15->0, count_gray 0x8->0x0, single-bit step, gray_err stays 0.
- rst_n low for one cycle while pending=5 and in HOLD -> next cycle all outputs 0, inc_ready=1; a subsequent single request publishes count=1.
- Checker build: force count_gray via testbench override to a two-bit jump (0x1->0x7) -> gray_err=1 next cycle and stays set until rst_n low.
